// File: rtl/band_mixer_pkg.sv
// Shared constants and the round/saturate helper for the three-band mixer.
package band_mixer_pkg;

   localparam int GAIN_FRAC  = 14;
   localparam int GAIN_UNITY = 16384;

   localparam int LP        = 0;
   localparam int BP        = 1;
   localparam int HP        = 2;
   localparam int NUM_BANDS = 3;

   typedef struct packed {
      logic signed [63:0] value;
      logic               clip;
   } sat_t;

   // Half-up rounding of a Q.GAIN_FRAC sum, then clamp to a signed width-bit range.
   function automatic sat_t round_sat(input logic signed [63:0] sum, input int width);
      sat_t               res;
      logic signed [63:0] rounded;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      rounded   = (sum + (64'sd1 <<< (GAIN_FRAC - 1))) >>> GAIN_FRAC;
      hi        = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo        = -hi - 64'sd1;
      res.value = rounded;
      res.clip  = 1'b0;
      if (rounded > hi) begin
         res.value = hi;
         res.clip  = 1'b1;
      end else if (rounded < lo) begin
         res.value = lo;
         res.clip  = 1'b1;
      end
      return res;
   endfunction

endpackage

// File: rtl/band_mixer_if.sv
// AXI-stream style handshake bundle used for both the band input and the mixed output.
interface band_mixer_if #(
   parameter int DATA_W = 16
) ();
   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tready;
   logic              tlast;

   modport master (output tdata, output tvalid, output tlast, input  tready);
   modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/band_mixer_gain_mult.sv
// band_gain_mult: registered signed sample x gain product with a valid bit, stalled by en_i.
module band_gain_mult #(
   parameter int DATA_WIDTH = 16,
   parameter int GAIN_WIDTH = 16
) (
   input  logic                                   clk_i,
   input  logic                                   rst_i,
   input  logic                                   en_i,
   input  logic                                   valid_i,
   input  logic signed [DATA_WIDTH-1:0]           sample_i,
   input  logic signed [GAIN_WIDTH-1:0]           gain_i,
   output logic signed [DATA_WIDTH+GAIN_WIDTH-1:0] product_o,
   output logic                                   valid_o
);
   localparam int PROD_W = DATA_WIDTH + GAIN_WIDTH;

   logic signed [PROD_W-1:0] product_d;
   logic signed [PROD_W-1:0] product_q;
   logic                     valid_q;

   assign product_d = PROD_W'(sample_i) * PROD_W'(gain_i);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         product_q <= '0;
         valid_q   <= 1'b0;
      end else if (en_i) begin
         product_q <= product_d;
         valid_q   <= valid_i;
      end
   end

   assign product_o = product_q;
   assign valid_o   = valid_q;

endmodule

// File: rtl/band_mixer.sv
// Three-band gain mixer: per-band multiply, sum, round/saturate, with packet-safe gain updates.
module band_mixer
   import band_mixer_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int GAIN_WIDTH = 16
) (
   input  logic                         pi_clk,
   input  logic                         pi_sreset,
   band_mixer_if.slave                  pi_data,
   band_mixer_if.master                 po_data,
   input  logic signed [GAIN_WIDTH-1:0] pi_lp_gain,
   input  logic signed [GAIN_WIDTH-1:0] pi_bp_gain,
   input  logic signed [GAIN_WIDTH-1:0] pi_hp_gain,
   input  logic                         pi_gain_load,
   input  logic                         pi_clr_clip,
   output logic                         po_gain_pending,
   output logic                         po_clip,
   output logic                         po_clip_sticky
);
   localparam int PROD_W = DATA_WIDTH + GAIN_WIDTH;
   localparam int SUM_W  = PROD_W + 2;

   logic en;
   logic accept;
   logic apply;

   logic signed [GAIN_WIDTH-1:0] gain_req   [NUM_BANDS];
   logic signed [GAIN_WIDTH-1:0] gain_shd_q [NUM_BANDS];
   logic signed [GAIN_WIDTH-1:0] gain_shd_d [NUM_BANDS];
   logic signed [GAIN_WIDTH-1:0] gain_act_q [NUM_BANDS];
   logic signed [GAIN_WIDTH-1:0] gain_act_d [NUM_BANDS];
   logic                         pending_q, pending_d;
   logic                         in_pkt_q, in_pkt_d;

   logic signed [PROD_W-1:0]     prod [NUM_BANDS];
   logic [NUM_BANDS-1:0]         s1_valid;
   logic                         s1_last_q;
   logic signed [SUM_W-1:0]      sum_d, sum_q;
   logic                         s2_valid_q, s2_last_q;
   sat_t                         sat;
   logic                         out_valid_q, out_last_q, out_clip_q;
   logic [DATA_WIDTH-1:0]        out_data_q;
   logic                         sticky_q, sticky_d;

   // A full output register that is not being taken freezes every stage at once.
   assign en             = !out_valid_q || po_data.tready;
   assign accept         = pi_data.tvalid && en;
   assign pi_data.tready = en;

   assign gain_req[LP] = pi_lp_gain;
   assign gain_req[BP] = pi_bp_gain;
   assign gain_req[HP] = pi_hp_gain;

   always_comb begin
      gain_shd_d = gain_shd_q;
      gain_act_d = gain_act_q;
      pending_d  = pending_q;
      in_pkt_d   = in_pkt_q;
      // Only swap gains in a true gap between packets so no packet sees two gain sets.
      apply      = pending_q && !in_pkt_q && !accept;
      if (apply) begin
         gain_act_d = gain_shd_q;
         pending_d  = 1'b0;
      end
      if (pi_gain_load) begin
         gain_shd_d = gain_req;
         pending_d  = 1'b1;
      end
      if (accept) begin
         in_pkt_d = !pi_data.tlast;
      end
   end

   always_ff @(posedge pi_clk) begin
      if (pi_sreset) begin
         for (int b = 0; b < NUM_BANDS; b++) begin
            gain_shd_q[b] <= GAIN_WIDTH'(GAIN_UNITY);
            gain_act_q[b] <= GAIN_WIDTH'(GAIN_UNITY);
         end
         pending_q <= 1'b0;
         in_pkt_q  <= 1'b0;
      end else begin
         gain_shd_q <= gain_shd_d;
         gain_act_q <= gain_act_d;
         pending_q  <= pending_d;
         in_pkt_q   <= in_pkt_d;
      end
   end

   for (genvar b = 0; b < NUM_BANDS; b++) begin : g_band
      band_gain_mult #(
         .DATA_WIDTH (DATA_WIDTH),
         .GAIN_WIDTH (GAIN_WIDTH)
      ) u_mult (
         .clk_i     (pi_clk),
         .rst_i     (pi_sreset),
         .en_i      (en),
         .valid_i   (accept),
         .sample_i  (pi_data.tdata[b*DATA_WIDTH +: DATA_WIDTH]),
         .gain_i    (gain_act_q[b]),
         .product_o (prod[b]),
         .valid_o   (s1_valid[b])
      );
   end

   assign sum_d = SUM_W'(prod[LP]) + SUM_W'(prod[BP]) + SUM_W'(prod[HP]);
   assign sat   = round_sat(64'(sum_q), DATA_WIDTH);

   always_ff @(posedge pi_clk) begin
      if (pi_sreset) begin
         s1_last_q   <= 1'b0;
         s2_valid_q  <= 1'b0;
         s2_last_q   <= 1'b0;
         sum_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_clip_q  <= 1'b0;
      end else if (en) begin
         s1_last_q   <= pi_data.tlast;
         s2_valid_q  <= &s1_valid;
         s2_last_q   <= s1_last_q;
         sum_q       <= sum_d;
         out_valid_q <= s2_valid_q;
         out_data_q  <= DATA_WIDTH'(sat.value);
         out_last_q  <= s2_last_q;
         out_clip_q  <= sat.clip;
      end
   end

   always_comb begin
      sticky_d = sticky_q;
      if (pi_clr_clip) begin
         sticky_d = 1'b0;
      end
      if (out_valid_q && po_data.tready && out_clip_q) begin
         sticky_d = 1'b1;
      end
   end

   always_ff @(posedge pi_clk) begin
      if (pi_sreset) begin
         sticky_q <= 1'b0;
      end else begin
         sticky_q <= sticky_d;
      end
   end

   assign po_data.tvalid  = out_valid_q;
   assign po_data.tdata   = out_data_q;
   assign po_data.tlast   = out_last_q;
   assign po_clip         = out_clip_q;
   assign po_clip_sticky  = sticky_q;
   assign po_gain_pending = pending_q;

endmodule

// File: tb/tb_band_mixer.sv
// Self-checking bench for band_mixer: vector table, directed corner sequences, random traffic vs. a queue model.
module tb_band_mixer;

   logic               clk = 1'b0;
   logic               sreset;
   logic signed [15:0] lp_gain, bp_gain, hp_gain;
   logic               gain_load, clr_clip;
   logic               po_gain_pending, po_clip, po_clip_sticky;

   band_mixer_if #(.DATA_W(48)) in_if ();
   band_mixer_if #(.DATA_W(16)) out_if ();

   band_mixer #(.DATA_WIDTH(16), .GAIN_WIDTH(16)) dut (
      .pi_clk          (clk),
      .pi_sreset       (sreset),
      .pi_data         (in_if),
      .po_data         (out_if),
      .pi_lp_gain      (lp_gain),
      .pi_bp_gain      (bp_gain),
      .pi_hp_gain      (hp_gain),
      .pi_gain_load    (gain_load),
      .pi_clr_clip     (clr_clip),
      .po_gain_pending (po_gain_pending),
      .po_clip         (po_clip),
      .po_clip_sticky  (po_clip_sticky)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: exact integer mix, floor((sum + 0.5 LSB)), clamp to 16 bits.
   function automatic longint ref_mix(input longint s0, s1, s2, g0, g1, g2, output bit clip);
      longint acc, q;
      acc = s0 * g0 + s1 * g1 + s2 * g2 + 64'sd8192;
      if (acc >= 0) q = acc / 16384;
      else          q = -((-acc + 16383) / 16384);
      clip = 1'b0;
      if (q > 32767) begin
         q = 32767; clip = 1'b1;
      end else if (q < -32768) begin
         q = -32768; clip = 1'b1;
      end
      return q;
   endfunction

   typedef struct {
      longint data;
      bit     last;
      bit     clip;
      int     acc_cyc;
   } exp_t;

   exp_t        expq[$];
   longint      got_q[$];
   longint      m_act[3], m_shd[3];
   bit          m_pend, m_inpkt, m_sticky;
   bit          stall_prev;
   logic [15:0] prev_data;
   logic        prev_last, prev_clip;
   int          out_count = 0;
   longint      last_out_data;
   bit          last_out_clip;
   int          last_latency;

   always @(negedge clk) begin : mon
      bit     acc, ohs, eclip, sset;
      longint od;
      exp_t   e;
      if (sreset) begin
         expq.delete();
         for (int b = 0; b < 3; b++) begin
            m_act[b] = 16384;
            m_shd[b] = 16384;
         end
         m_pend = 0; m_inpkt = 0; m_sticky = 0; stall_prev = 0;
      end else begin
         acc  = in_if.tvalid && in_if.tready;
         ohs  = out_if.tvalid && out_if.tready;
         sset = 0;
         check("gain_pending", po_gain_pending, m_pend);
         check("clip_sticky", po_clip_sticky, m_sticky);
         if (stall_prev) begin
            check("hold_valid", out_if.tvalid, 1);
            check("hold_data", out_if.tdata, prev_data);
            check("hold_last", out_if.tlast, prev_last);
            check("hold_clip", po_clip, prev_clip);
         end
         if (ohs) begin
            od = $signed(out_if.tdata);
            out_count++;
            got_q.push_back(od);
            last_out_data = od;
            last_out_clip = po_clip;
            if (expq.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_output: got beat %0d, expected no beat (cycle %0d)", od, cyc);
            end else begin
               e = expq.pop_front();
               check("out_data", od, e.data);
               check("out_last", out_if.tlast, e.last);
               check("out_clip", po_clip, e.clip);
               last_latency = cyc - e.acc_cyc;
               sset = e.clip;
            end
         end
         if (acc) begin
            e.data = ref_mix($signed(in_if.tdata[15:0]), $signed(in_if.tdata[31:16]),
                             $signed(in_if.tdata[47:32]), m_act[0], m_act[1], m_act[2], eclip);
            e.clip    = eclip;
            e.last    = in_if.tlast;
            e.acc_cyc = cyc;
            expq.push_back(e);
         end
         if (m_pend && !m_inpkt && !acc) begin
            m_act  = m_shd;
            m_pend = 0;
         end
         if (gain_load) begin
            m_shd[0] = lp_gain; m_shd[1] = bp_gain; m_shd[2] = hp_gain;
            m_pend   = 1;
         end
         if (acc) m_inpkt = !in_if.tlast;
         if (sset) m_sticky = 1;
         else if (clr_clip) m_sticky = 0;
         stall_prev = out_if.tvalid && !out_if.tready;
         prev_data  = out_if.tdata;
         prev_last  = out_if.tlast;
         prev_clip  = po_clip;
      end
   end

   // All driver tasks start and end 1 time unit after a rising edge.
   task automatic send_beat(input int lp, input int bp, input int hp, input bit last);
      bit done = 0;
      in_if.tdata  = {16'(hp), 16'(bp), 16'(lp)};
      in_if.tvalid = 1'b1;
      in_if.tlast  = last;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         done = in_if.tready;
         @(posedge clk);
         #1;
      end
      in_if.tvalid = 1'b0;
      in_if.tlast  = 1'b0;
      if (!done) check("send_timeout", 0, 1);
   endtask

   task automatic apply_gains(input int g0, input int g1, input int g2);
      lp_gain   = 16'(g0);
      bp_gain   = 16'(g1);
      hp_gain   = 16'(g2);
      gain_load = 1'b1;
      @(posedge clk); #1;
      gain_load = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic wait_count(input int target);
      bit ok = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
         if (out_count >= target) ok = 1;
         else begin
            @(posedge clk); #1;
         end
      end
      if (!ok) check("wait_timeout", out_count, target);
   endtask

   typedef struct {
      int g0, g1, g2;
      int lp, bp, hp;
      int exp_data;
      bit exp_clip;
   } vec_t;

   vec_t tbl[10];

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int n0;
      bit seen, acc_prev;
      int t;

      tbl[0] = '{16384, 16384, 16384,   1000,   2000,   3000,   6000, 1'b0};
      tbl[1] = '{16384, 16384, 16384,  20000,  20000,  20000,  32767, 1'b1};
      tbl[2] = '{16384, 16384, 16384, -20000, -20000, -20000, -32768, 1'b1};
      tbl[3] = '{ 8192,     0,     0,      3,      0,      0,      2, 1'b0};
      tbl[4] = '{ 8192,     0,     0,     -3,      0,      0,     -1, 1'b0};
      tbl[5] = '{ 8192,     0,     0,      1,      0,      0,      1, 1'b0};
      tbl[6] = '{ 8192,     0,     0,     -1,      0,      0,      0, 1'b0};
      tbl[7] = '{-16384,    0,     0, -32768,      0,      0,  32767, 1'b1};
      tbl[8] = '{16384, -16384, 8192,    100,     50,     10,     55, 1'b0};
      tbl[9] = '{32767, 32767, 32767,  32767,  32767,  32767,  32767, 1'b1};

      sreset       = 1'b1;
      in_if.tvalid = 1'b0;
      in_if.tlast  = 1'b0;
      in_if.tdata  = '0;
      out_if.tready = 1'b1;
      lp_gain = 16'sd16384; bp_gain = 16'sd16384; hp_gain = 16'sd16384;
      gain_load = 1'b0;
      clr_clip  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      sreset = 1'b0;

      check("rst_out_tvalid", out_if.tvalid, 0);
      check("rst_out_tdata", out_if.tdata, 0);
      check("rst_out_tlast", out_if.tlast, 0);
      check("rst_clip", po_clip, 0);
      check("rst_sticky", po_clip_sticky, 0);
      check("rst_pending", po_gain_pending, 0);
      check("rst_in_tready", in_if.tready, 1);

      for (int i = 0; i < 10; i++) begin
         apply_gains(tbl[i].g0, tbl[i].g1, tbl[i].g2);
         n0 = out_count;
         send_beat(tbl[i].lp, tbl[i].bp, tbl[i].hp, 1'b1);
         wait_count(n0 + 1);
         check("tbl_data", last_out_data, tbl[i].exp_data);
         check("tbl_clip", last_out_clip, tbl[i].exp_clip);
         if (i == 0) check("tbl_latency", last_latency, 3);
         if (tbl[i].exp_clip) begin
            check("tbl_sticky_set", po_clip_sticky, 1);
            clr_clip = 1'b1;
            @(posedge clk); #1;
            clr_clip = 1'b0;
            check("tbl_sticky_clr", po_clip_sticky, 0);
         end
      end

      // 20-beat stream with a 5-cycle output stall on beat 7.
      apply_gains(16384, 16384, 16384);
      got_q.delete();
      n0   = out_count;
      seen = 0;
      fork
         begin
            for (int v = 1; v <= 20; v++) send_beat(v, 0, 0, v == 20);
         end
         begin
            for (int i = 0; i < 300 && !seen; i++) begin
               @(negedge clk);
               if (out_if.tvalid && out_if.tdata == 16'd6) seen = 1;
            end
            @(posedge clk); #1;
            out_if.tready = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            out_if.tready = 1'b1;
         end
      join
      check("stream_stall_seen", seen, 1);
      wait_count(n0 + 20);
      check("stream_count", got_q.size(), 20);
      for (int i = 0; i < 20 && i < got_q.size(); i++) check("stream_beat", got_q[i], i + 1);

      // Gain load mid-packet waits for the inter-packet gap.
      got_q.delete();
      n0 = out_count;
      send_beat(100, 0, 0, 0);
      lp_gain   = 16'sd0;
      gain_load = 1'b1;
      send_beat(100, 0, 0, 0);
      gain_load = 1'b0;
      check("pend_in_pkt_b2", po_gain_pending, 1);
      send_beat(100, 0, 0, 0);
      check("pend_in_pkt_b3", po_gain_pending, 1);
      send_beat(100, 0, 0, 1);
      check("pend_at_tlast", po_gain_pending, 1);
      @(posedge clk); #1;
      check("pend_after_gap", po_gain_pending, 0);
      send_beat(100, 0, 0, 1);
      wait_count(n0 + 5);
      check("pkt_count", got_q.size(), 5);
      for (int i = 0; i < 5 && i < got_q.size(); i++) check("pkt_beat", got_q[i], (i < 4) ? 100 : 0);

      // Reset with three beats stalled inside the pipeline.
      apply_gains(0, 16384, 16384);
      out_if.tready = 1'b0;
      for (int i = 0; i < 3; i++) send_beat(200, 0, 0, 0);
      check("flight_out_valid", out_if.tvalid, 1);
      check("flight_in_stalled", in_if.tready, 0);
      sreset = 1'b1;
      @(posedge clk); #1;
      sreset = 1'b0;
      check("rst2_in_tready", in_if.tready, 1);
      check("rst2_out_tvalid", out_if.tvalid, 0);
      check("rst2_pending", po_gain_pending, 0);
      out_if.tready = 1'b1;
      n0 = out_count;
      repeat (6) begin
         @(posedge clk); #1;
         check("rst2_no_ghost", out_if.tvalid, 0);
      end
      send_beat(500, 0, 0, 1);
      wait_count(n0 + 1);
      check("rst2_unity_data", last_out_data, 500);
      check("rst2_latency", last_latency, 3);

      // Random traffic, backpressure, gain loads and clip clears.
      acc_prev = 0;
      for (int c = 0; c < 400; c++) begin
         if (!in_if.tvalid || acc_prev) begin
            in_if.tvalid = ($urandom_range(0, 3) != 0);
            t = $urandom_range(0, 40000); in_if.tdata[15:0]  = 16'(t - 20000);
            t = $urandom_range(0, 40000); in_if.tdata[31:16] = 16'(t - 20000);
            t = $urandom_range(0, 40000); in_if.tdata[47:32] = 16'(t - 20000);
            in_if.tlast = ($urandom_range(0, 3) == 0);
         end
         out_if.tready = ($urandom_range(0, 3) != 0);
         gain_load     = ($urandom_range(0, 15) == 0);
         if (gain_load) begin
            t = $urandom_range(0, 24576); lp_gain = 16'(t - 8192);
            t = $urandom_range(0, 24576); bp_gain = 16'(t - 8192);
            t = $urandom_range(0, 24576); hp_gain = 16'(t - 8192);
         end
         clr_clip = ($urandom_range(0, 31) == 0);
         @(negedge clk);
         acc_prev = in_if.tvalid && in_if.tready;
         @(posedge clk); #1;
      end
      in_if.tvalid  = 1'b0;
      in_if.tlast   = 1'b0;
      out_if.tready = 1'b1;
      gain_load     = 1'b0;
      clr_clip      = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("drain_empty", expq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
